resv_station: RTL and testbench

- Parametrised reservation station succeeding the fixed single-broadcast `rs` used by the dispatch stage.
- Holds up to DEPTH renamed ops waiting on lhs, rhs and flags operands.
- Snoops NBC completion broadcast buses and captures operand values by tag.
- Issues the oldest fully-ready op to an execution unit through a valid/accept handshake.
- Sits between rename/dispatch and the ALU, FADD and FMUL execute pipes; one instance per execution cluster.

---
 rtl/resv_station.sv | 193 +++++++++++++++++++
 tb/tb_resv_station.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/resv_station.sv
// Collapsing age-ordered reservation station: captures operands from NBC
// broadcast buses by tag and issues the oldest fully-ready op.

module resv_station_cap #(
  parameter int W    = 32,
  parameter int TAGW = 6,
  parameter int NBC  = 2
) (
  input  logic              valid,
  input  logic [TAGW-1:0]   tag,
  input  logic [W-1:0]      value,
  input  logic [NBC-1:0]    bc_en,
  input  logic [NBC*TAGW-1:0] bc_tag,
  input  logic [NBC*W-1:0]  bc_data,
  output logic              valid_n,
  output logic [W-1:0]      value_n
);
  // scan high-to-low so the lowest matching bus wins
  always_comb begin
    valid_n = valid;
    value_n = value;
    if (!valid) begin
      for (int b = NBC-1; b >= 0; b--) begin
        if (bc_en[b] && bc_tag[b*TAGW +: TAGW] == tag) begin
          valid_n = 1'b1;
          value_n = bc_data[b*W +: W];
        end
      end
    end
  end
endmodule

module resv_station #(
  parameter int DATAW  = 32,
  parameter int TAGW   = 6,
  parameter int FLAGSW = 4,
  parameter int EXTRAW = 14,
  parameter int DEPTH  = 8,
  parameter int NBC    = 2,
  parameter int CNTW   = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_lhs_valid,
  input  logic                   in_rhs_valid,
  input  logic                   in_flags_valid,
  input  logic [TAGW-1:0]        in_lhs_tag,
  input  logic [TAGW-1:0]        in_rhs_tag,
  input  logic [TAGW-1:0]        in_flags_tag,
  input  logic [DATAW-1:0]       in_lhs_value,
  input  logic [DATAW-1:0]       in_rhs_value,
  input  logic [FLAGSW-1:0]      in_flags_value,
  input  logic [EXTRAW-1:0]      in_extra,
  input  logic [TAGW-1:0]        in_dest_tag,
  input  logic [NBC-1:0]         bc_en,
  input  logic [NBC*TAGW-1:0]    bc_tag,
  input  logic [NBC*DATAW-1:0]   bc_value,
  input  logic [NBC*FLAGSW-1:0]  bc_flags,
  output logic                   out_valid,
  input  logic                   out_accept,
  output logic [DATAW-1:0]       out_lhs,
  output logic [DATAW-1:0]       out_rhs,
  output logic [FLAGSW-1:0]      out_flags,
  output logic [EXTRAW-1:0]      out_extra,
  output logic [TAGW-1:0]        out_dest_tag,
  output logic [CNTW-1:0]        count
);
  localparam int SELW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  typedef struct packed {
    logic              lv;
    logic [TAGW-1:0]   lt;
    logic [DATAW-1:0]  lval;
    logic              rv;
    logic [TAGW-1:0]   rt;
    logic [DATAW-1:0]  rval;
    logic              fv;
    logic [TAGW-1:0]   ft;
    logic [FLAGSW-1:0] fval;
    logic [EXTRAW-1:0] extra;
    logic [TAGW-1:0]   dest;
  } ent_t;

  ent_t [DEPTH-1:0] ent_q, ent_d;
  ent_t [DEPTH:0]   cap;
  ent_t             nin, sel_ent;
  logic [CNTW-1:0]  count_q, count_d, widx;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] c_lv, c_rv, c_fv;
  logic [DEPTH-1:0][DATAW-1:0]  c_lval, c_rval;
  logic [DEPTH-1:0][FLAGSW-1:0] c_fval;
  logic             n_lv, n_rv, n_fv;
  logic [DATAW-1:0] n_lval, n_rval;
  logic [FLAGSW-1:0] n_fval;
  logic [SELW-1:0]  sel;
  logic             issue, disp;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      resv_station_cap #(.W(DATAW), .TAGW(TAGW), .NBC(NBC)) u_lhs (
        .valid(ent_q[i].lv), .tag(ent_q[i].lt), .value(ent_q[i].lval),
        .bc_en(bc_en), .bc_tag(bc_tag), .bc_data(bc_value),
        .valid_n(c_lv[i]), .value_n(c_lval[i]));
      resv_station_cap #(.W(DATAW), .TAGW(TAGW), .NBC(NBC)) u_rhs (
        .valid(ent_q[i].rv), .tag(ent_q[i].rt), .value(ent_q[i].rval),
        .bc_en(bc_en), .bc_tag(bc_tag), .bc_data(bc_value),
        .valid_n(c_rv[i]), .value_n(c_rval[i]));
      resv_station_cap #(.W(FLAGSW), .TAGW(TAGW), .NBC(NBC)) u_flg (
        .valid(ent_q[i].fv), .tag(ent_q[i].ft), .value(ent_q[i].fval),
        .bc_en(bc_en), .bc_tag(bc_tag), .bc_data(bc_flags),
        .valid_n(c_fv[i]), .value_n(c_fval[i]));
      assign rdy[i] = (CNTW'(i) < count_q) && ent_q[i].lv && ent_q[i].rv && ent_q[i].fv;
    end
  endgenerate

  // same capture path applied to the incoming op gives the dispatch bypass
  resv_station_cap #(.W(DATAW), .TAGW(TAGW), .NBC(NBC)) u_in_lhs (
    .valid(in_lhs_valid), .tag(in_lhs_tag), .value(in_lhs_value),
    .bc_en(bc_en), .bc_tag(bc_tag), .bc_data(bc_value),
    .valid_n(n_lv), .value_n(n_lval));
  resv_station_cap #(.W(DATAW), .TAGW(TAGW), .NBC(NBC)) u_in_rhs (
    .valid(in_rhs_valid), .tag(in_rhs_tag), .value(in_rhs_value),
    .bc_en(bc_en), .bc_tag(bc_tag), .bc_data(bc_value),
    .valid_n(n_rv), .value_n(n_rval));
  resv_station_cap #(.W(FLAGSW), .TAGW(TAGW), .NBC(NBC)) u_in_flg (
    .valid(in_flags_valid), .tag(in_flags_tag), .value(in_flags_value),
    .bc_en(bc_en), .bc_tag(bc_tag), .bc_data(bc_flags),
    .valid_n(n_fv), .value_n(n_fval));

  always_comb begin
    nin = '{lv: n_lv, lt: in_lhs_tag, lval: n_lval,
            rv: n_rv, rt: in_rhs_tag, rval: n_rval,
            fv: n_fv, ft: in_flags_tag, fval: n_fval,
            extra: in_extra, dest: in_dest_tag};
    cap = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cap[k]      = ent_q[k];
      cap[k].lv   = c_lv[k];
      cap[k].lval = c_lval[k];
      cap[k].rv   = c_rv[k];
      cap[k].rval = c_rval[k];
      cap[k].fv   = c_fv[k];
      cap[k].fval = c_fval[k];
    end
  end

  always_comb begin
    sel = '0;
    for (int k = DEPTH-1; k >= 0; k--)
      if (rdy[k]) sel = k[SELW-1:0];
  end

  assign out_valid    = |rdy;
  assign sel_ent      = ent_q[sel];
  assign out_lhs      = out_valid ? sel_ent.lval  : '0;
  assign out_rhs      = out_valid ? sel_ent.rval  : '0;
  assign out_flags    = out_valid ? sel_ent.fval  : '0;
  assign out_extra    = out_valid ? sel_ent.extra : '0;
  assign out_dest_tag = out_valid ? sel_ent.dest  : '0;

  assign in_ready = (count_q != FULL);
  assign count    = count_q;
  assign issue    = out_valid && out_accept;
  assign disp     = in_valid && in_ready;
  assign widx     = count_q - CNTW'(issue);
  assign count_d  = count_q + CNTW'(disp) - CNTW'(issue);

  // entries at/above the issued slot collapse down; new op lands at the tail
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_d[k] = (issue && k >= int'(sel)) ? cap[k+1] : cap[k];
      if (disp && CNTW'(k) == widx) ent_d[k] = nin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q   <= '0;
      count_q <= '0;
    end else if (flush) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_resv_station.sv
// Scoreboard bench for resv_station: expected issues queued as stimulus makes
// ops ready, popped and compared whenever an issue handshake happens.

module tb_resv_station;
  localparam int DATAW = 32, TAGW = 6, FLAGSW = 4, EXTRAW = 14, DEPTH = 8, NBC = 2;
  localparam int CNTW = $clog2(DEPTH+1);

  logic clk, rst, flush, in_valid, in_ready;
  logic in_lhs_valid, in_rhs_valid, in_flags_valid;
  logic [TAGW-1:0] in_lhs_tag, in_rhs_tag, in_flags_tag, in_dest_tag;
  logic [DATAW-1:0] in_lhs_value, in_rhs_value;
  logic [FLAGSW-1:0] in_flags_value;
  logic [EXTRAW-1:0] in_extra;
  logic [NBC-1:0] bc_en;
  logic [NBC*TAGW-1:0] bc_tag;
  logic [NBC*DATAW-1:0] bc_value;
  logic [NBC*FLAGSW-1:0] bc_flags;
  logic out_valid, out_accept;
  logic [DATAW-1:0] out_lhs, out_rhs;
  logic [FLAGSW-1:0] out_flags;
  logic [EXTRAW-1:0] out_extra;
  logic [TAGW-1:0] out_dest_tag;
  logic [CNTW-1:0] count;

  resv_station #(.DATAW(DATAW), .TAGW(TAGW), .FLAGSW(FLAGSW), .EXTRAW(EXTRAW),
                 .DEPTH(DEPTH), .NBC(NBC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lhs_valid(in_lhs_valid), .in_rhs_valid(in_rhs_valid), .in_flags_valid(in_flags_valid),
    .in_lhs_tag(in_lhs_tag), .in_rhs_tag(in_rhs_tag), .in_flags_tag(in_flags_tag),
    .in_lhs_value(in_lhs_value), .in_rhs_value(in_rhs_value), .in_flags_value(in_flags_value),
    .in_extra(in_extra), .in_dest_tag(in_dest_tag),
    .bc_en(bc_en), .bc_tag(bc_tag), .bc_value(bc_value), .bc_flags(bc_flags),
    .out_valid(out_valid), .out_accept(out_accept), .out_lhs(out_lhs), .out_rhs(out_rhs),
    .out_flags(out_flags), .out_extra(out_extra), .out_dest_tag(out_dest_tag), .count(count));

  typedef struct {
    logic [DATAW-1:0]  lhs, rhs;
    logic [FLAGSW-1:0] flags;
    logic [TAGW-1:0]   dest;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && out_valid && out_accept) begin
      if (sb.size() == 0) chk("sb_unexpected_issue", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("iss_lhs", out_lhs, e.lhs);
        chk("iss_rhs", out_rhs, e.rhs);
        chk("iss_flags", 32'(out_flags), 32'(e.flags));
        chk("iss_dest", 32'(out_dest_tag), 32'(e.dest));
        chk("iss_extra", 32'(out_extra), 32'({e.dest, 8'hA5}));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r, input logic [3:0] f,
                      input logic [5:0] d);
    exp_t e;
    e.lhs = l; e.rhs = r; e.flags = f; e.dest = d;
    sb.push_back(e);
  endtask

  task automatic set_in(input logic lv, input logic [5:0] lt, input logic [31:0] lval,
                        input logic rv, input logic [5:0] rt, input logic [31:0] rval,
                        input logic fv, input logic [5:0] ft, input logic [3:0] fval,
                        input logic [5:0] dest);
    in_valid = 1'b1;
    in_lhs_valid = lv; in_lhs_tag = lt; in_lhs_value = lval;
    in_rhs_valid = rv; in_rhs_tag = rt; in_rhs_value = rval;
    in_flags_valid = fv; in_flags_tag = ft; in_flags_value = fval;
    in_dest_tag = dest; in_extra = {dest, 8'hA5};
  endtask

  task automatic disp(input logic lv, input logic [5:0] lt, input logic [31:0] lval,
                      input logic rv, input logic [5:0] rt, input logic [31:0] rval,
                      input logic [3:0] fval, input logic [5:0] dest);
    set_in(lv, lt, lval, rv, rt, rval, 1'b1, 6'd0, fval, dest);
    step();
    in_valid = 1'b0;
  endtask

  task automatic bc(input logic [1:0] en, input logic [5:0] t0, input logic [31:0] v0,
                    input logic [5:0] t1, input logic [31:0] v1);
    bc_en = en; bc_tag = {t1, t0}; bc_value = {v1, v0}; bc_flags = {4'h9, 4'h6};
  endtask

  task automatic accept_n(input int n);
    out_accept = 1'b1;
    for (int k = 0; k < n; k++) step();
    out_accept = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_accept = 1'b0; in_valid = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    bc(2'b00, 0, 0, 0, 0);
    #12 rst = 1'b0;
    step();

    // reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_lhs", out_lhs, 0);
    chk("rst_out_dest", 32'(out_dest_tag), 0);

    // T1: ready op, no same-cycle pass-through
    set_in(1, 0, 5, 1, 0, 7, 1, 0, 0, 3);
    #1 chk("t1_no_pass", 32'(out_valid), 0);
    push(5, 7, 0, 3);
    step(); in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_lhs", out_lhs, 5);
    chk("t1_rhs", out_rhs, 7);
    chk("t1_dest", 32'(out_dest_tag), 3);
    chk("t1_count1", 32'(count), 1);
    accept_n(1);
    chk("t1_count0", 32'(count), 0);
    chk("t1_valid0", 32'(out_valid), 0);

    // T2: lhs waiting on tag 9, captured from bus 1
    disp(0, 9, 0, 1, 0, 1, 2, 4);
    chk("t2_wait", 32'(out_valid), 0);
    bc(2'b10, 0, 0, 9, 32'hDEAD);
    push(32'hDEAD, 1, 2, 4);
    step(); bc(2'b00, 0, 0, 0, 0);
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_lhs", out_lhs, 32'hDEAD);
    accept_n(1);

    // T2b: wrong tag ignored; both buses match -> bus 0 wins (value and flags)
    set_in(0, 12, 0, 1, 0, 2, 0, 12, 0, 5); step(); in_valid = 1'b0;
    bc(2'b11, 13, 32'h999, 13, 32'h998);
    step();
    chk("t2b_no_match", 32'(out_valid), 0);
    bc(2'b11, 12, 32'h111, 12, 32'h222);
    push(32'h111, 2, 4'h6, 5);
    step(); bc(2'b00, 0, 0, 0, 0);
    chk("t2b_lhs", out_lhs, 32'h111);
    accept_n(1);

    // T3: dispatch bypass on rhs; valid lhs with matching tag not overwritten
    set_in(1, 4, 20, 0, 4, 0, 1, 0, 0, 6);
    bc(2'b01, 4, 11, 0, 0);
    push(20, 11, 0, 6);
    step(); in_valid = 1'b0; bc(2'b00, 0, 0, 0, 0);
    chk("t3_valid", 32'(out_valid), 1);
    chk("t3_rhs", out_rhs, 11);
    chk("t3_lhs_kept", out_lhs, 20);
    accept_n(1);

    // T4: younger ready op issues before older waiting op
    disp(0, 2, 0, 1, 0, 32'hA, 0, 10);
    disp(1, 0, 32'hB1, 1, 0, 32'hB2, 1, 11);
    push(32'hB1, 32'hB2, 1, 11);
    chk("t4_count2", 32'(count), 2);
    chk("t4_sel_young", 32'(out_dest_tag), 11);
    accept_n(1);
    chk("t4_a_waits", 32'(out_valid), 0);
    chk("t4_count1", 32'(count), 1);
    bc(2'b01, 2, 32'h22, 0, 0);
    push(32'h22, 32'hA, 0, 10);
    step(); bc(2'b00, 0, 0, 0, 0);
    chk("t4_sel_old", 32'(out_dest_tag), 10);
    accept_n(1);

    // T4b: capture on the same edge that collapses the waiting entry down
    disp(1, 0, 32'h30, 1, 0, 32'h31, 3, 20);
    disp(0, 5, 0, 1, 0, 32'h41, 0, 21);
    push(32'h30, 32'h31, 3, 20);
    out_accept = 1'b1;
    bc(2'b01, 5, 32'h55, 0, 0);
    push(32'h55, 32'h41, 0, 21);
    step(); bc(2'b00, 0, 0, 0, 0);
    chk("t4b_shift_cap", 32'(out_dest_tag), 21);
    step(); out_accept = 1'b0;
    chk("t4b_count0", 32'(count), 0);

    // T5: fill to DEPTH, extra request held off, then drain
    for (int i = 0; i < DEPTH; i++) begin
      disp(1, 0, 32'(i*3), 1, 0, 32'(i+100), 4'(i), 6'(i+32));
      push(32'(i*3), 32'(i+100), 4'(i), 6'(i+32));
    end
    chk("t5_count8", 32'(count), 8);
    chk("t5_full", 32'(in_ready), 0);
    set_in(1, 0, 1, 1, 0, 1, 1, 0, 0, 63); step(); in_valid = 1'b0;
    chk("t5_held_off", 32'(count), 8);
    chk("t5_oldest", 32'(out_dest_tag), 32);
    accept_n(1);
    chk("t5_ready_again", 32'(in_ready), 1);
    chk("t5_count7", 32'(count), 7);
    accept_n(7);
    chk("t5_drained", 32'(count), 0);

    // T6: flush overrides dispatch and issue; async reset mid-stream
    for (int i = 0; i < 5; i++) disp(1, 0, 32'(i), 1, 0, 32'(i), 0, 6'(40+i));
    chk("t6_count5", 32'(count), 5);
    set_in(1, 0, 9, 1, 0, 9, 1, 0, 0, 50);
    flush = 1'b1; out_accept = 1'b1;
    step(); flush = 1'b0; out_accept = 1'b0; in_valid = 1'b0;
    chk("t6_flush_count", 32'(count), 0);
    chk("t6_flush_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3; i++) disp(1, 0, 1, 1, 0, 1, 0, 6'(50+i));
    chk("t6_count3", 32'(count), 3);
    #2 rst = 1'b1;
    #1 chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_ready", 32'(in_ready), 1);
    #2 rst = 1'b0;
    step();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
